uart_rx_packet: RTL and testbench

Serial receiver that sits directly downstream of the 128-bit UART transmit path. It deserialises 8N1 frames (LSB first, idle-high) and reassembles NUM_BYTES consecutive bytes into one wide word, with the first received byte in the MSBs. It presents the word with a one-cycle valid strobe and flags framing errors and stalled partial packets. At the default CLKS_PER_BIT=1 it is bit-compatible with the one-bit-per-clock transmitter on the same clk.

---
 rtl/uart_rx_packet.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_packet.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet.sv
// -----------------------------------------------------------------------------
// uart_rx_packet
//
// Receives 8N1 serial frames (LSB first, line idle high) and packs
// NUM_BYTES consecutive bytes into one wide word. The first byte received
// ends up in the most significant byte. The word is presented on data_out
// together with a one-cycle data_valid strobe. A low stop bit drops the
// whole partial packet and raises frame_err. A partial packet that sits idle
// for IDLE_TIMEOUT cycles between bytes is dropped and raises pkt_abort.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rxd        serial input, idle high (asynchronous to clk)
//   data_out   last complete packet; first byte in [8*NUM_BYTES-1 -: 8]
//   data_valid one-cycle pulse when data_out updates
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   pkt_abort  one-cycle pulse when a partial packet times out
//   busy       high while a frame is in progress or a packet is partial
// -----------------------------------------------------------------------------
module uart_rx_packet #(
   parameter int CLKS_PER_BIT = 1,
   parameter int NUM_BYTES    = 16,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rxd,
   output logic [8*NUM_BYTES-1:0] data_out,
   output logic                   data_valid,
   output logic                   frame_err,
   output logic                   pkt_abort,
   output logic                   busy
);

   localparam int W   = 8 * NUM_BYTES;
   localparam int TW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BCW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int ICW = $clog2(IDLE_TIMEOUT);

   localparam logic [TW-1:0]  HALF      = TW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [TW-1:0]  FULL      = TW'(CLKS_PER_BIT - 1);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);
   localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   logic           rx_meta;
   logic           rxs;
   logic           rxs_d;

   state_t         state,      state_nxt;
   logic [TW-1:0]  timer,      timer_nxt;
   logic [2:0]     bit_cnt,    bit_cnt_nxt;
   logic [7:0]     rx_byte,    rx_byte_nxt;
   logic [W-1:0]   shreg,      shreg_nxt;
   logic [BCW-1:0] byte_cnt,   byte_cnt_nxt;
   logic [ICW-1:0] idle_cnt,   idle_cnt_nxt;
   logic [W-1:0]   data_out_nxt;
   logic           dv_nxt, fe_nxt, pa_nxt;

   logic           tmr_done;
   logic [W-1:0]   shreg_shift;

   // Two-flop synchroniser, idle-high reset so no false start after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
      end
   end

   // Start detection looks at rxs directly; every later sample (start
   // confirmation, data, stop) looks at rxs_d, one cycle behind. This lets
   // the sample grid be anchored on the detection cycle itself, so with
   // HALF=0 the start confirmation uses the detecting sample and data bits
   // follow on consecutive cycles at one bit per clock.
   assign tmr_done    = (timer == '0);
   assign shreg_shift = W'({shreg, rx_byte});

   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      bit_cnt_nxt  = bit_cnt;
      rx_byte_nxt  = rx_byte;
      shreg_nxt    = shreg;
      byte_cnt_nxt = byte_cnt;
      idle_cnt_nxt = '0;
      data_out_nxt = data_out;
      dv_nxt       = 1'b0;
      fe_nxt       = 1'b0;
      pa_nxt       = 1'b0;

      case (state)
         S_IDLE: begin
            // A start edge wins over a timeout expiring on the same cycle.
            if (!rxs) begin
               state_nxt = S_START;
               timer_nxt = HALF;
            end else if (byte_cnt != '0) begin
               if (idle_cnt == IDLE_LAST) begin
                  pa_nxt       = 1'b1;
                  byte_cnt_nxt = '0;
               end else begin
                  idle_cnt_nxt = idle_cnt + ICW'(1);
               end
            end
         end

         S_START: begin
            if (tmr_done) begin
               if (!rxs_d) begin
                  state_nxt   = S_DATA;
                  timer_nxt   = FULL;
                  bit_cnt_nxt = '0;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end

         S_DATA: begin
            if (tmr_done) begin
               rx_byte_nxt = {rxs_d, rx_byte[7:1]};
               timer_nxt   = FULL;
               if (bit_cnt == 3'd7) begin
                  state_nxt = S_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end

         S_STOP: begin
            if (tmr_done) begin
               if (rxs_d) begin
                  shreg_nxt = shreg_shift;
                  if (byte_cnt == LAST_BYTE) begin
                     data_out_nxt = shreg_shift;
                     dv_nxt       = 1'b1;
                     byte_cnt_nxt = '0;
                  end else begin
                     byte_cnt_nxt = byte_cnt + BCW'(1);
                  end
                  // At one clock per bit the next start bit is already on
                  // rxs here; catch it now so zero-gap frames are not lost.
                  if (!rxs) begin
                     state_nxt = S_START;
                     timer_nxt = HALF;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end else begin
                  fe_nxt       = 1'b1;
                  byte_cnt_nxt = '0;
                  state_nxt    = S_WAIT_HIGH;
               end
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end

         S_WAIT_HIGH: begin
            if (rxs) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         timer      <= '0;
         bit_cnt    <= '0;
         rx_byte    <= '0;
         shreg      <= '0;
         byte_cnt   <= '0;
         idle_cnt   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         pkt_abort  <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         bit_cnt    <= bit_cnt_nxt;
         rx_byte    <= rx_byte_nxt;
         shreg      <= shreg_nxt;
         byte_cnt   <= byte_cnt_nxt;
         idle_cnt   <= idle_cnt_nxt;
         data_out   <= data_out_nxt;
         data_valid <= dv_nxt;
         frame_err  <= fe_nxt;
         pkt_abort  <= pa_nxt;
      end
   end

   assign busy = (state != S_IDLE) || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_rx_packet.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_packet
//
// Two receivers share clk and rst_n: dut1 at one clock per bit and dut16 at
// sixteen clocks per bit. Stimulus processes push expected strobes into a
// per-receiver queue; a monitor on each receiver pops and compares whenever
// data_valid, frame_err or pkt_abort is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx_packet;

   localparam int NB = 16;
   localparam int TO = 64;

   typedef struct {
      int           kind;   // 0 data_valid, 1 frame_err, 2 pkt_abort
      logic [127:0] data;
      longint       cyc;    // expected cycle, -1 when not checked
   } ev_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rxd1 = 1'b1;
   logic         rxd16 = 1'b1;
   logic [127:0] data1, data16;
   logic         dv1, fe1, pa1, busy1;
   logic         dv16, fe16, pa16, busy16;

   longint       cyc = 0;
   int           checks = 0;
   int           failures = 0;
   ev_t          q1[$];
   ev_t          q16[$];

   uart_rx_packet #(.CLKS_PER_BIT(1), .NUM_BYTES(NB), .IDLE_TIMEOUT(TO)) dut1 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd1), .data_out(data1),
      .data_valid(dv1), .frame_err(fe1), .pkt_abort(pa1), .busy(busy1));

   uart_rx_packet #(.CLKS_PER_BIT(16), .NUM_BYTES(NB), .IDLE_TIMEOUT(TO)) dut16 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd16), .data_out(data16),
      .data_valid(dv16), .frame_err(fe16), .pkt_abort(pa16), .busy(busy16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic mon(input int id, input logic dv, input logic fe, input logic pa,
                      input logic [127:0] d);
      ev_t e;
      int  kind;
      if (dv || fe || pa) begin
         checks++;
         if ((int'(dv) + int'(fe) + int'(pa)) > 1) begin
            failures++;
            $display("FAIL strobes_exclusive dut%0d dv=%0b fe=%0b pa=%0b", id, dv, fe, pa);
         end
         kind = dv ? 0 : (fe ? 1 : 2);
         if ((id == 1 && q1.size() == 0) || (id == 16 && q16.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_strobe dut%0d kind=%0d cyc=%0d", id, kind, cyc);
         end else begin
            e = (id == 1) ? q1.pop_front() : q16.pop_front();
            if (e.kind != kind || (kind == 0 && d !== e.data)) begin
               failures++;
               $display("FAIL event dut%0d actual kind=%0d data=%h expected kind=%0d data=%h",
                        id, kind, d, e.kind, e.data);
            end
            if (e.cyc >= 0) begin
               checks++;
               if (cyc != e.cyc) begin
                  failures++;
                  $display("FAIL event_cycle dut%0d kind=%0d actual=%0d expected=%0d",
                           id, kind, cyc, e.cyc);
               end
            end
         end
      end
   endtask

   always @(negedge clk) mon(1, dv1, fe1, pa1, data1);
   always @(negedge clk) mon(16, dv16, fe16, pa16, data16);

   // ---------------- stimulus: one clock per bit ----------------
   // Each drive lands 1 time unit after an edge; when a task returns, cyc
   // is the index of the edge that captured the last driven bit.
   task automatic bit1(input logic v);
      rxd1 = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle1(input int n);
      repeat (n) bit1(1'b1);
   endtask

   task automatic byte1(input logic [7:0] b, input logic stop, output longint stop_edge);
      bit1(1'b0);
      for (int i = 0; i < 8; i++) bit1(b[i]);
      bit1(stop);
      stop_edge = cyc;
   endtask

   // Strobe appears 3 cycles after the stop bit's capture edge: two
   // synchroniser flops plus the registered strobe.
   task automatic pkt1(input logic [127:0] d);
      longint e;
      for (int i = NB - 1; i >= 0; i--) byte1(d[8*i +: 8], 1'b1, e);
      q1.push_back('{kind: 0, data: d, cyc: e + 3});
   endtask

   // ---------------- stimulus: sixteen clocks per bit ----------------
   task automatic bits16(input logic v, input int n);
      rxd16 = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Interior bit edges are moved by -1/0/+1 cycles around the nominal grid.
   task automatic byte16(input logic [7:0] b, input int seed);
      logic [9:0] fb;
      int         j[11];
      fb = {1'b1, b, 1'b0};
      j[0] = 0;
      j[10] = 0;
      for (int k = 1; k < 10; k++) j[k] = ((k + seed) % 3) - 1;
      for (int k = 0; k < 10; k++) bits16(fb[k], 16 + j[k+1] - j[k]);
   endtask

   task automatic pkt16(input logic [127:0] d);
      q16.push_back('{kind: 0, data: d, cyc: -1});
      for (int i = NB - 1; i >= 0; i--) byte16(d[8*i +: 8], i);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      longint e;
      logic [127:0] p2;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_out1", data1, '0);
      chk("reset_strobes1", {dv1, fe1, pa1}, 3'b000);
      chk("reset_busy1", busy1, 1'b0);
      chk("reset_data_out16", data16, '0);
      chk("reset_busy16", busy16, 1'b0);
      rst_n = 1'b1;
      idle1(4);

      // Single packet
      pkt1(128'h00112233445566778899AABBCCDDEEFF);
      idle1(6);
      chk("busy_after_pkt", busy1, 1'b0);
      chk("data_out_pkt1", data1, 128'h00112233445566778899AABBCCDDEEFF);

      // Two packets, zero gap between every frame
      p2 = 128'h0123456789ABCDEF0011223344556677;
      pkt1({128{1'b1}});
      pkt1(p2);
      idle1(6);
      chk("busy_after_b2b", busy1, 1'b0);

      // Stop bit low on the fifth byte drops the packet
      for (int i = 0; i < 4; i++) byte1(8'h3C + 8'(i), 1'b1, e);
      chk("busy_partial", busy1, 1'b1);
      byte1(8'h5A, 1'b0, e);
      q1.push_back('{kind: 1, data: '0, cyc: e + 3});
      idle1(5);
      chk("data_out_hold_ferr", data1, p2);
      chk("busy_after_ferr", busy1, 1'b0);
      pkt1(128'hFEDCBA98765432100F1E2D3C4B5A6978);
      idle1(4);

      // Three bytes then idle: abort IDLE_TIMEOUT cycles after the counter starts
      for (int i = 0; i < 3; i++) byte1(8'hC0 + 8'(i), 1'b1, e);
      q1.push_back('{kind: 2, data: '0, cyc: e + 3 + TO});
      idle1(TO + 10);
      chk("busy_after_abort", busy1, 1'b0);
      pkt1({16{8'hA5}});
      idle1(4);

      // Sixteen clocks per bit: short glitch, then a jittered packet
      bits16(1'b0, 2);
      bits16(1'b1, 200);
      chk("glitch_busy16", busy16, 1'b0);
      chk("glitch_data16", data16, '0);
      pkt16(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
      bits16(1'b1, 40);
      chk("busy16_after_pkt", busy16, 1'b0);

      // Reset in the middle of byte 9
      for (int i = 0; i < 8; i++) byte1(8'h11 * 8'(i + 1), 1'b1, e);
      bit1(1'b0);
      bit1(1'b1);
      bit1(1'b0);
      rxd1 = 1'b1;
      rst_n = 1'b0;
      #2;
      chk("midrst_data_out1", data1, '0);
      chk("midrst_strobes1", {dv1, fe1, pa1}, 3'b000);
      chk("midrst_busy1", busy1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle1(4);
      chk("postrst_busy1", busy1, 1'b0);
      pkt1(128'hDEADBEEF0102030405060708090A0B0C);
      idle1(20);

      chk("queue1_drained", 128'(q1.size()), '0);
      chk("queue16_drained", 128'(q16.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
